// File: rtl/pad_port_reader_pkg.sv
// Shared SMPC port definitions: FSM states, transaction status codes and pin levels.
package pad_port_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D_DRIVE,
        D_SETTLE,
        H_HDR,
        H_TOGGLE,
        H_WAIT,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_OVERSIZE = 2'b10
    } status_t;

    localparam logic [7:0] ID_DIRECT = 8'h02;
    localparam logic [1:0] THTR_IDLE = 2'b11;
    localparam logic [6:0] DDR_VAL   = 7'h60;

    function automatic logic [6:0] pdro_of(input logic [1:0] thtr);
        return {thtr, 5'b0_0000};
    endfunction

endpackage

// File: rtl/pad_port_reader_nibble_packer.sv
// Pairs hi/lo nibbles into bytes with a saturating 0-based index; strobe registered, 1 CE tick.
// Hi may be loaded on the same tick as lo, in which case the incoming hi is used directly.
module pad_nibble_packer (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       i_clr,
    input  logic       i_hi_ld,
    input  logic [3:0] i_hi,
    input  logic       i_lo_vld,
    input  logic [3:0] i_lo,
    output logic       o_vld,
    output logic [7:0] o_dat,
    output logic [3:0] o_idx
);
    logic [3:0] r_hi;
    logic [3:0] r_next_idx;
    logic       r_vld;
    logic [7:0] r_dat;
    logic [3:0] r_idx;
    logic [3:0] w_hi;

    assign w_hi = i_hi_ld ? i_hi : r_hi;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hi       <= 4'h0;
            r_next_idx <= 4'h0;
            r_vld      <= 1'b0;
            r_dat      <= 8'h00;
            r_idx      <= 4'h0;
        end else if (CE) begin
            r_vld <= i_lo_vld;
            if (i_hi_ld) begin
                r_hi <= i_hi;
            end
            if (i_clr) begin
                r_next_idx <= 4'h0;
            end else if (i_lo_vld) begin
                r_dat <= {w_hi, i_lo};
                r_idx <= r_next_idx;
                if (r_next_idx != 4'hF) begin
                    r_next_idx <= r_next_idx + 4'h1;
                end
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_idx = r_idx;

endmodule

// File: rtl/pad_port_reader.sv
// Saturn port initiator: direct TH/TR scan (4*(SETTLE+1)+1 CE ticks) or TL-paced 3-wire handshake.
// No downstream backpressure; peripheral stalls are bounded by TIMEOUT CE ticks per TR edge.
module pad_port_reader
    import pad_port_reader_pkg::*;
#(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_BYTES = 15
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       START,
    input  logic       MODE,
    input  logic [6:0] PDRI,
    output logic [6:0] PDRO,
    output logic [6:0] DDR,
    output logic       BUSY,
    output logic [7:0] ID,
    output logic       OUT_VALID,
    output logic [7:0] OUT_DATA,
    output logic [3:0] OUT_IDX,
    output logic       DONE,
    output logic [1:0] STATUS
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TO_M1     = CW'(TIMEOUT - 1);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_thtr, w_thtr_nx;
    logic [1:0]    r_phase, w_phase_nx;
    logic [5:0]    r_nib, w_nib_nx;
    logic [7:0]    r_id, w_id_nx;
    logic [1:0]    r_status, w_status_nx;
    logic          r_busy, w_busy_nx;
    logic          r_done, w_done_nx;
    logic [3:0]    r_n00, w_n00_nx;
    logic          w_clr, w_hi_ld, w_lo_vld;
    logic [3:0]    w_hi;
    logic [5:0]    w_k;
    logic [5:0]    w_last;
    logic          w_unused_pdri;

    assign w_unused_pdri = ^PDRI[6:5];
    assign w_k           = r_nib + 6'd1;
    // Final nibble index: two ID nibbles plus two per data byte.
    assign w_last        = 6'd2 + {1'b0, r_id[3:0], 1'b0};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_thtr   <= THTR_IDLE;
            r_phase  <= 2'd0;
            r_nib    <= 6'd0;
            r_id     <= 8'h00;
            r_status <= ST_OK;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_n00    <= 4'h0;
        end else if (CE) begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_thtr   <= w_thtr_nx;
            r_phase  <= w_phase_nx;
            r_nib    <= w_nib_nx;
            r_id     <= w_id_nx;
            r_status <= w_status_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_n00    <= w_n00_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_thtr_nx   = r_thtr;
        w_phase_nx  = r_phase;
        w_nib_nx    = r_nib;
        w_id_nx     = r_id;
        w_status_nx = r_status;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_n00_nx    = r_n00;
        w_clr       = 1'b0;
        w_hi_ld     = 1'b0;
        w_hi        = PDRI[3:0];
        w_lo_vld    = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_busy_nx   = 1'b1;
                    w_clr       = 1'b1;
                    w_id_nx     = 8'h00;
                    w_status_nx = ST_OK;
                    w_cnt_nx    = '0;
                    w_nib_nx    = 6'd0;
                    w_phase_nx  = 2'd0;
                    if (MODE) begin
                        w_thtr_nx  = 2'b01;
                        w_state_nx = H_HDR;
                    end else begin
                        w_thtr_nx  = 2'b00;
                        w_state_nx = D_SETTLE;
                    end
                end
            end
            D_SETTLE: begin
                if (r_cnt == SETTLE_M1) w_state_nx = D_DRIVE;
                else                    w_cnt_nx   = r_cnt + 1'b1;
            end
            D_DRIVE: begin
                // byte0 = {n01,n10}, byte1 = {n00,n11}; n00 is parked until the last phase.
                case (r_phase)
                    2'd0:    w_n00_nx = PDRI[3:0];
                    2'd1:    w_hi_ld  = 1'b1;
                    2'd2:    w_lo_vld = 1'b1;
                    default: begin
                        w_hi_ld  = 1'b1;
                        w_hi     = r_n00;
                        w_lo_vld = 1'b1;
                    end
                endcase
                if (r_phase == 2'd3) begin
                    w_id_nx    = ID_DIRECT;
                    w_state_nx = FINISH;
                end else begin
                    w_phase_nx = r_phase + 2'd1;
                    w_thtr_nx  = r_phase + 2'd1;
                    w_cnt_nx   = '0;
                    w_state_nx = D_SETTLE;
                end
            end
            H_HDR: begin
                if (r_cnt == SETTLE_M1) w_state_nx = H_TOGGLE;
                else                    w_cnt_nx   = r_cnt + 1'b1;
            end
            H_TOGGLE: begin
                w_thtr_nx  = {r_thtr[1], ~r_thtr[0]};
                w_cnt_nx   = '0;
                w_state_nx = H_WAIT;
            end
            H_WAIT: begin
                if (PDRI[4] == r_thtr[0]) begin
                    w_nib_nx   = w_k;
                    w_state_nx = H_TOGGLE;
                    if (w_k == 6'd1) begin
                        w_id_nx[7:4] = PDRI[3:0];
                    end else if (w_k == 6'd2) begin
                        w_id_nx[3:0] = PDRI[3:0];
                        if (PDRI[3:0] == 4'h0) begin
                            w_state_nx = FINISH;
                        end else if (int'(PDRI[3:0]) > MAX_BYTES) begin
                            w_status_nx = ST_OVERSIZE;
                            w_state_nx  = FINISH;
                        end
                    end else begin
                        if (w_k[0]) w_hi_ld  = 1'b1;
                        else        w_lo_vld = 1'b1;
                        if (w_k == w_last) w_state_nx = FINISH;
                    end
                end else if (r_cnt >= TO_M1) begin
                    w_status_nx = ST_TIMEOUT;
                    w_state_nx  = FINISH;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            FINISH: begin
                w_thtr_nx  = THTR_IDLE;
                w_busy_nx  = 1'b0;
                w_done_nx  = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    pad_nibble_packer u_packer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CE       (CE),
        .i_clr    (w_clr),
        .i_hi_ld  (w_hi_ld),
        .i_hi     (w_hi),
        .i_lo_vld (w_lo_vld),
        .i_lo     (PDRI[3:0]),
        .o_vld    (OUT_VALID),
        .o_dat    (OUT_DATA),
        .o_idx    (OUT_IDX)
    );

    assign PDRO   = pdro_of(r_thtr);
    assign DDR    = DDR_VAL;
    assign BUSY   = r_busy;
    assign ID     = r_id;
    assign DONE   = r_done;
    assign STATUS = r_status;

endmodule

// File: tb/tb_pad_port_reader.sv
// Directed bench for pad_port_reader with a behavioural Saturn peripheral on the port pins.
module tb_pad_port_reader;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE = 1'b1;
    logic       MODE;
    logic [6:0] PDRI;
    logic       start_a, start_b, sel, stretch;

    logic [6:0] pdro_a, ddr_a, pdro_b, ddr_b;
    logic       busy_a, busy_b, vld_a, vld_b, done_a, done_b;
    logic [7:0] id_a, id_b, dat_a, dat_b;
    logic [3:0] idx_a, idx_b;
    logic [1:0] st_a, st_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pad_port_reader #(.SETTLE(4), .TIMEOUT(255), .MAX_BYTES(15)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(start_a), .MODE(MODE), .PDRI(PDRI),
        .PDRO(pdro_a), .DDR(ddr_a), .BUSY(busy_a), .ID(id_a), .OUT_VALID(vld_a),
        .OUT_DATA(dat_a), .OUT_IDX(idx_a), .DONE(done_a), .STATUS(st_a)
    );

    pad_port_reader #(.SETTLE(4), .TIMEOUT(255), .MAX_BYTES(8)) u_dut8 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(start_b), .MODE(MODE), .PDRI(PDRI),
        .PDRO(pdro_b), .DDR(ddr_b), .BUSY(busy_b), .ID(id_b), .OUT_VALID(vld_b),
        .OUT_DATA(dat_b), .OUT_IDX(idx_b), .DONE(done_b), .STATUS(st_b)
    );

    wire [6:0] m_pdro = sel ? pdro_b : pdro_a;
    wire       m_busy = sel ? busy_b : busy_a;
    wire       m_vld  = sel ? vld_b  : vld_a;
    wire       m_done = sel ? done_b : done_a;
    wire [7:0] m_id   = sel ? id_b   : id_a;
    wire [7:0] m_dat  = sel ? dat_b  : dat_a;
    wire [3:0] m_idx  = sel ? idx_b  : idx_a;
    wire [1:0] m_st   = sel ? st_b   : st_a;

    // Peripheral: direct table indexed by TH/TR; handshake nibble k follows the k-th TR edge.
    logic [3:0] seq [0:15];
    logic [3:0] dtab [0:3];
    int         stop_at;
    int         k;
    logic       prev_tr;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k <= 0;
            prev_tr <= 1'b1;
        end else if (m_pdro[6]) begin
            k <= 0;
            prev_tr <= 1'b1;
        end else if (m_pdro[5] != prev_tr) begin
            prev_tr <= m_pdro[5];
            if (k < stop_at) k <= k + 1;
        end
    end

    always_comb begin
        if (MODE) PDRI = {2'b00, ~k[0], seq[k[3:0]]};
        else      PDRI = {2'b00, 1'b1, dtab[m_pdro[6:5]]};
    end

    int         ce_cnt = 0;
    int         cap_n = 0;
    int         n_done = 0;
    int         d_cnt = 0;
    logic [7:0] cap_dat [0:63];
    logic [3:0] cap_idx [0:63];
    logic [7:0] d_id;
    logic [1:0] d_st;
    logic [6:0] d_pdro;
    logic       d_busy;
    int         t_start;

    always @(posedge CLK) if (CE) ce_cnt <= ce_cnt + 1;

    always @(negedge CLK) begin
        if (CE && m_vld) begin
            cap_dat[cap_n % 64] <= m_dat;
            cap_idx[cap_n % 64] <= m_idx;
            cap_n <= cap_n + 1;
        end
        if (CE && m_done) begin
            n_done <= n_done + 1;
            d_id   <= m_id;
            d_st   <= m_st;
            d_pdro <= m_pdro;
            d_busy <= m_busy;
            d_cnt  <= ce_cnt;
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        CE = stretch ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_seq(input logic [63:0] w, input int stop);
        for (int i = 0; i < 16; i++) seq[i] = w[63-4*i -: 4];
        stop_at = stop;
    endtask

    task automatic pulse_start(input logic to_b);
        @(posedge CLK);
        #1;
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        @(negedge CLK);
        while (!CE) @(negedge CLK);
        @(posedge CLK);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        t_start = ce_cnt;
    endtask

    task automatic wait_done(input string tag, input int prev, input int budget);
        int i = 0;
        while (n_done == prev && i < budget) begin
            @(posedge CLK);
            i++;
        end
        check({tag, "_done_seen"}, 32'(n_done != prev), 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int base, input int n, input logic [63:0] exp);
        check({tag, "_nbytes"}, 32'(cap_n - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(cap_dat[(base + i) % 64]), 32'(exp[8*(n-1-i) +: 8]));
            check($sformatf("%s_idx%0d", tag, i), 32'(cap_idx[(base + i) % 64]), 32'(i));
        end
    endtask

    initial begin
        int base;
        int nd;
        RST_N = 1'b0; MODE = 1'b0; start_a = 1'b0; start_b = 1'b0;
        sel = 1'b0; stretch = 1'b0;
        load_seq(64'h015FFFF807F00000, 100);
        dtab[0] = 4'hF; dtab[1] = 4'hF; dtab[2] = 4'h7; dtab[3] = 4'hF;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_pdro", 32'(pdro_a), 32'h60);
        check("rst_ddr", 32'(ddr_a), 32'h60);
        check("rst_ddr8", 32'(ddr_b), 32'h60);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_valid", 32'(vld_a), 32'd0);
        check("rst_id", 32'(id_a), 32'd0);
        check("rst_data", 32'(dat_a), 32'd0);
        check("rst_idx", 32'(idx_a), 32'd0);
        check("rst_status", 32'(st_a), 32'd0);

        // Direct scan, pad word F7FF
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        check("dir_busy_rise", 32'(busy_a), 32'd1);
        check("dir_phase0_pdro", 32'(pdro_a), 32'h00);
        wait_done("dir", nd, 200);
        check("dir_latency", 32'(d_cnt - t_start), 32'd21);
        check("dir_id", 32'(d_id), 32'h02);
        check("dir_status", 32'(d_st), 32'd0);
        check("dir_pdro_end", 32'(d_pdro), 32'h60);
        check("dir_busy_end", 32'(d_busy), 32'd0);
        check_bytes("dir", base, 2, 64'hF7FF);

        // Direct scan, distinct nibbles to expose pairing order
        dtab[0] = 4'h1; dtab[1] = 4'h2; dtab[2] = 4'h3; dtab[3] = 4'h4;
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        wait_done("dir2", nd, 200);
        check_bytes("dir2", base, 2, 64'h2314);

        // Mission stick handshake
        MODE = 1'b1;
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        check("hs_hdr_pdro", 32'(pdro_a), 32'h20);
        wait_done("hs", nd, 500);
        check("hs_id", 32'(d_id), 32'h15);
        check("hs_status", 32'(d_st), 32'd0);
        check("hs_pdro_end", 32'(d_pdro), 32'h60);
        check_bytes("hs", base, 5, 64'hFFFF807F00);

        // TL stalls after 8 nibbles
        load_seq(64'h01FA1B2C3DDDDDDD, 8);
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        wait_done("to", nd, 2000);
        check("to_status", 32'(d_st), 32'd1);
        check("to_id", 32'(d_id), 32'h1F);
        check("to_pdro_end", 32'(d_pdro), 32'h60);
        check("to_duration", 32'((d_cnt - t_start) > 255), 32'd1);
        check_bytes("to", base, 3, 64'hA1B2C3);

        // Oversize on MAX_BYTES=8 instance
        load_seq(64'h01FA1B2C3DDDDDDD, 100);
        sel = 1'b1;
        base = cap_n; nd = n_done;
        pulse_start(1'b1);
        wait_done("ovs", nd, 200);
        check("ovs_status", 32'(d_st), 32'd2);
        check("ovs_id", 32'(d_id), 32'h1F);
        check("ovs_pdro_end", 32'(d_pdro), 32'h60);
        check_bytes("ovs", base, 0, 64'h0);
        sel = 1'b0;

        // Zero-length peripheral
        load_seq(64'h0300000000000000, 100);
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        wait_done("zero", nd, 200);
        check("zero_id", 32'(d_id), 32'h30);
        check("zero_status", 32'(d_st), 32'd0);
        check_bytes("zero", base, 0, 64'h0);

        // Asynchronous reset mid-handshake, then a clean run
        load_seq(64'h015FFFF807F00000, 100);
        nd = n_done;
        pulse_start(1'b0);
        repeat (25) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("arst_pdro", 32'(pdro_a), 32'h60);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_valid", 32'(vld_a), 32'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        check("arst_no_done", 32'(n_done), 32'(nd));
        base = cap_n;
        pulse_start(1'b0);
        wait_done("post_rst", nd, 500);
        check("post_rst_id", 32'(d_id), 32'h15);
        check_bytes("post_rst", base, 5, 64'hFFFF807F00);

        // CE gaps plus a START while busy
        stretch = 1'b1;
        base = cap_n; nd = n_done;
        pulse_start(1'b0);
        repeat (10) @(posedge CLK);
        pulse_start(1'b0);
        wait_done("ce", nd, 5000);
        repeat (300) @(posedge CLK);
        stretch = 1'b0;
        check("ce_single_done", 32'(n_done), 32'(nd + 1));
        check("ce_busy_end", 32'(busy_a), 32'd0);
        check("ce_id", 32'(d_id), 32'h15);
        check("ce_status", 32'(d_st), 32'd0);
        check_bytes("ce", base, 5, 64'hFFFF807F00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
